hkspi_master_wb: RTL and testbench

// Wishbone-slave-controlled SPI master driving the housekeeping SPI slave (striVe_spi) from the SoC side.

---
 rtl/hkspi_master_wb_if.sv | 22 ++
 rtl/hkspi_master_wb.sv | 202 ++++++++++++++++++++
 tb/tb_hkspi_master_wb.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hkspi_master_wb_if.sv
// Wishbone slave bundle for hkspi_master_wb: strobe/cycle/write-enable, byte selects,
// address and data in both directions, plus the registered acknowledge.
interface hkspi_master_wb_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_adr_i;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i, wb_dat_i, wb_adr_i,
    output wb_ack_o, wb_dat_o
  );

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i, wb_dat_i, wb_adr_i,
    input  wb_ack_o, wb_dat_o
  );
endinterface

// File: rtl/hkspi_master_wb.sv
// Wishbone-controlled mode-0 SPI master issuing 24-bit housekeeping register frames (cmd, addr, data).
// Optional HKSPI_MASTER_IRQ_EN adds an irq output (done & CTRL[17] ien, readback at STATUS[11]).
module hkspi_master_wb #(
  parameter logic [31:0] BASE_ADR   = 32'h2600_0000,
  parameter logic [7:0]  CLKDIV_RST = 8'd1
) (
  input  logic                    wb_clk_i,
  input  logic                    resetn,
  hkspi_master_wb_if.slave        wb,
  output logic                    CSB,
  output logic                    SCK,
  output logic                    SDI,
  input  logic                    SDO
`ifdef HKSPI_MASTER_IRQ_EN
  ,
  output logic                    irq
`endif
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SETUP = 2'd1, ST_HIGH = 2'd2, ST_LOW = 2'd3} state_t;

  state_t      state_r, state_nxt_s;
  logic [7:0]  cnt_r, cnt_nxt_s, div_r, div_lat_r, rdata_r, rx_r, rx_nxt_s;
  logic [23:0] shift_r, shift_nxt_s, frame_s;
  logic [4:0]  bits_r, bits_nxt_s;
  logic        rw_r, done_r, ovr_r, ack_r, csb_r, sck_r, sdi_r;
  logic        done_nxt_s, ovr_nxt_s, ien_s;
  logic [31:0] dat_r, rd_mux_s, status_s;
  logic [1:0]  off_s;
  logic        req_s, ctrl_wr_s, div_wr_s, stat_rd_s, start_s, busy_s, phase_end_s, frame_end_s;
  logic        unused_s;

  assign req_s       = wb.wb_stb_i & wb.wb_cyc_i & ~ack_r & (wb.wb_adr_i[31:4] == BASE_ADR[31:4]);
  assign off_s       = wb.wb_adr_i[3:2];
  assign ctrl_wr_s   = req_s & wb.wb_we_i & (off_s == 2'd0);
  assign div_wr_s    = req_s & wb.wb_we_i & (off_s == 2'd2);
  assign stat_rd_s   = req_s & ~wb.wb_we_i & (off_s == 2'd1);
  assign busy_s      = (state_r != ST_IDLE);
  assign start_s     = ctrl_wr_s & ~busy_s;
  assign phase_end_s = (cnt_r == div_lat_r);
  assign frame_end_s = (state_r == ST_LOW) & phase_end_s & (bits_r == 5'd24);
  assign frame_s     = {wb.wb_dat_i[16] ? 8'h80 : 8'h40, wb.wb_dat_i[7:0],
                        wb.wb_dat_i[16] ? wb.wb_dat_i[15:8] : 8'h00};
  assign status_s    = {20'd0, ien_s, ovr_r, done_r, busy_s, rdata_r};

  // Frame sequencer: phase counter, bit shifter and SDO capture
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    shift_nxt_s = shift_r;
    bits_nxt_s  = bits_r;
    rx_nxt_s    = rx_r;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = 8'd0;
        if (start_s) begin
          state_nxt_s = ST_SETUP;
          shift_nxt_s = frame_s;
          bits_nxt_s  = 5'd0;
          rx_nxt_s    = 8'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (phase_end_s) begin
          state_nxt_s = ST_HIGH;
          cnt_nxt_s   = 8'd0;
        end else begin
          cnt_nxt_s = cnt_r + 8'd1;
        end
      end
      ST_HIGH: begin
        // SDO is taken on the last clock of the high phase; data advances as SCK falls
        if (phase_end_s) begin
          state_nxt_s = ST_LOW;
          cnt_nxt_s   = 8'd0;
          shift_nxt_s = {shift_r[22:0], 1'b0};
          rx_nxt_s    = {rx_r[6:0], SDO};
          bits_nxt_s  = bits_r + 5'd1;
        end else begin
          cnt_nxt_s = cnt_r + 8'd1;
        end
      end
      ST_LOW: begin
        if (phase_end_s) begin
          cnt_nxt_s   = 8'd0;
          state_nxt_s = (bits_r == 5'd24) ? ST_IDLE : ST_HIGH;
        end else begin
          cnt_nxt_s = cnt_r + 8'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 8'd0;
      end
    endcase
  end

  // Sequencer state and registered SPI pins
  always_ff @(posedge wb_clk_i or negedge resetn) begin
    if (!resetn) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 8'd0;
      shift_r   <= 24'd0;
      bits_r    <= 5'd0;
      rx_r      <= 8'd0;
      div_lat_r <= 8'd0;
      rw_r      <= 1'b0;
      csb_r     <= 1'b1;
      sck_r     <= 1'b0;
      sdi_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      shift_r   <= shift_nxt_s;
      bits_r    <= bits_nxt_s;
      rx_r      <= rx_nxt_s;
      div_lat_r <= start_s ? div_r : div_lat_r;
      rw_r      <= start_s ? wb.wb_dat_i[16] : rw_r;
      csb_r     <= (state_nxt_s == ST_IDLE);
      sck_r     <= (state_nxt_s == ST_HIGH);
      sdi_r     <= (state_nxt_s != ST_IDLE) & shift_nxt_s[23];
    end
  end

  // Sticky flags: a completing frame outranks a clearing STATUS read
  always_comb begin
    done_nxt_s = done_r;
    ovr_nxt_s  = ovr_r;
    if (frame_end_s) begin
      done_nxt_s = 1'b1;
    end else if (stat_rd_s) begin
      done_nxt_s = 1'b0;
    end else begin
      done_nxt_s = done_r;
    end
    if (ctrl_wr_s && busy_s) begin
      ovr_nxt_s = 1'b1;
    end else if (stat_rd_s) begin
      ovr_nxt_s = 1'b0;
    end else begin
      ovr_nxt_s = ovr_r;
    end
  end

  // Read-data multiplexer
  always_comb begin
    rd_mux_s = 32'd0;
    case (off_s)
      2'd1:    rd_mux_s = status_s;
      2'd2:    rd_mux_s = {24'd0, div_r};
      default: rd_mux_s = 32'd0;
    endcase
  end

  // Bus-side registers, acknowledge and status
  always_ff @(posedge wb_clk_i or negedge resetn) begin
    if (!resetn) begin
      ack_r   <= 1'b0;
      dat_r   <= 32'd0;
      div_r   <= CLKDIV_RST;
      rdata_r <= 8'd0;
      done_r  <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      ack_r   <= req_s;
      dat_r   <= (req_s && !wb.wb_we_i) ? rd_mux_s : 32'd0;
      div_r   <= div_wr_s ? wb.wb_dat_i[7:0] : div_r;
      rdata_r <= (frame_end_s && !rw_r) ? rx_r : rdata_r;
      done_r  <= done_nxt_s;
      ovr_r   <= ovr_nxt_s;
    end
  end

`ifdef HKSPI_MASTER_IRQ_EN
  logic ien_r, ien_nxt_s, irq_r;
  assign ien_nxt_s = start_s ? wb.wb_dat_i[17] : ien_r;
  assign ien_s     = ien_r;
  assign irq       = irq_r;
  assign unused_s  = ^{wb.wb_sel_i, wb.wb_adr_i[1:0], wb.wb_dat_i[31:18]};

  // Interrupt enable and registered interrupt level
  always_ff @(posedge wb_clk_i or negedge resetn) begin
    if (!resetn) begin
      ien_r <= 1'b0;
      irq_r <= 1'b0;
    end else begin
      ien_r <= ien_nxt_s;
      irq_r <= done_nxt_s & ien_nxt_s;
    end
  end
`else
  assign ien_s    = 1'b0;
  assign unused_s = ^{wb.wb_sel_i, wb.wb_adr_i[1:0], wb.wb_dat_i[31:17]};
`endif

  assign wb.wb_ack_o = ack_r;
  assign wb.wb_dat_o = dat_r;
  assign CSB         = csb_r;
  assign SCK         = sck_r;
  assign SDI         = sdi_r;
endmodule

// File: tb/tb_hkspi_master_wb.sv
// Self-checking bench for hkspi_master_wb: directed and random frames against a register-level
// model and a behavioural housekeeping SPI slave (mfgr_id 0x456).
module tb_hkspi_master_wb;
  localparam logic [31:0] BASE = 32'h2600_0000;
`ifdef HKSPI_MASTER_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic csb, sck, sdi;
  logic sdo = 1'b0;
`ifdef HKSPI_MASTER_IRQ_EN
  logic irq;
`endif

  always #5 clk = ~clk;

  hkspi_master_wb_if bus ();

  hkspi_master_wb dut (
    .wb_clk_i (clk),
    .resetn   (rst_n),
    .wb       (bus),
    .CSB      (csb),
    .SCK      (sck),
    .SDI      (sdi),
    .SDO      (sdo)
`ifdef HKSPI_MASTER_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [7:0]  m_div   = 8'd1;
  logic [7:0]  m_rdata = 8'd0;
  logic        m_ien   = 1'b0;
  logic [23:0] resp    = 24'd0;

  // monitor / slave state
  logic        prev_csb = 1'b1;
  logic        prev_sck = 1'b0;
  int          hi_cnt = 0, lo_cnt = 0, rises = 0, idx = 0;
  logic [23:0] sdi_word = 24'd0;

  function automatic logic [7:0] slave_reg(input logic [7:0] a);
    case (a)
      8'h01:   return 8'h04;
      8'h02:   return 8'h56;
      default: return a ^ 8'h3C;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // SPI monitor and behavioural slave, sampled away from the active edge
  always @(negedge clk) begin
    if (!csb && prev_csb) begin
      hi_cnt   <= 0;
      lo_cnt   <= 1;
      rises    <= 0;
      sdi_word <= 24'd0;
      idx      <= 0;
      sdo      <= resp[23];
    end else if (!csb) begin
      if (sck) hi_cnt <= hi_cnt + 1;
      else     lo_cnt <= lo_cnt + 1;
      if (sck && !prev_sck) begin
        sdi_word <= {sdi_word[22:0], sdi};
        rises    <= rises + 1;
      end
      if (!sck && prev_sck && idx < 23) begin
        idx <= idx + 1;
        sdo <= resp[22 - idx];
      end
    end
    prev_csb <= csb;
    prev_sck <= sck;
  end

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         output logic [31:0] rdat);
    int k;
    @(negedge clk);
    bus.wb_stb_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_sel_i = 4'hF;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = wdat;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.wb_ack_o !== 1'b1 && k < 8);
    check("ack_seen", {31'd0, bus.wb_ack_o}, 32'd1);
    rdat = bus.wb_dat_o;
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", {31'd0, bus.wb_ack_o}, 32'd0);
  endtask

  task automatic wait_csb_high();
    int k;
    k = 0;
    while (csb !== 1'b1 && k < 49 * 256 + 64) begin
      @(negedge clk);
      k++;
    end
    check("frame_end_timeout", {31'd0, csb}, 32'd1);
  endtask

  task automatic set_div(input logic [7:0] d);
    logic [31:0] rd;
    wb_xfer(1'b1, BASE + 32'h8, {24'hABCDEF, d}, rd);
    m_div = d;
    wb_xfer(1'b0, BASE + 32'h8, 32'd0, rd);
    check("clkdiv_rb", rd, {24'd0, d});
  endtask

  task automatic do_frame(input logic rw, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic ien, input logic inject);
    logic [31:0] rd;
    logic [23:0] exp_word;
    logic [15:0] junk;
    int p;
    p        = int'(m_div) + 1;
    exp_word = {rw ? 8'h80 : 8'h40, addr, rw ? wdata : 8'h00};
    junk     = 16'($urandom);
    resp     = {junk, slave_reg(addr)};
    wb_xfer(1'b1, BASE, {14'd0, ien, rw, wdata, addr}, rd);
    m_ien = ien & IRQ_EN;
    if (inject) begin
      wb_xfer(1'b1, BASE, {$urandom} ^ 32'h0001_FFFF, rd);
      wb_xfer(1'b1, BASE + 32'h8, 32'd2, rd);
    end
    wait_csb_high();
    check("sdi_word", {8'd0, sdi_word}, {8'd0, exp_word});
    check("sck_rises", rises, 24);
    check("sck_high_clks", hi_cnt, 24 * p);
    check("csb_low_clks", hi_cnt + lo_cnt, 49 * p);
    if (!rw) m_rdata = slave_reg(addr);
`ifdef HKSPI_MASTER_IRQ_EN
    @(negedge clk);
    check("irq_set", {31'd0, irq}, {31'd0, ien});
`endif
    wb_xfer(1'b0, BASE + 32'h4, 32'd0, rd);
    check("status_done", rd, {20'd0, m_ien, inject, 1'b1, 1'b0, m_rdata});
`ifdef HKSPI_MASTER_IRQ_EN
    check("irq_clr", {31'd0, irq}, 32'd0);
`endif
    wb_xfer(1'b0, BASE + 32'h4, 32'd0, rd);
    check("status_clr", rd, {20'd0, m_ien, 1'b0, 1'b0, 1'b0, m_rdata});
    if (inject) m_div = 8'd2;
  endtask

  initial begin
    logic [31:0] rd;
    int k;
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_sel_i = 4'h0;
    bus.wb_adr_i = 32'd0;
    bus.wb_dat_i = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_csb", {31'd0, csb}, 32'd1);
    check("rst_sck", {31'd0, sck}, 32'd0);
    check("rst_sdi", {31'd0, sdi}, 32'd0);
    check("rst_ack", {31'd0, bus.wb_ack_o}, 32'd0);
    check("rst_dat", bus.wb_dat_o, 32'd0);
    rst_n = 1'b1;
    wb_xfer(1'b0, BASE + 32'h4, 32'd0, rd);
    check("rst_status", rd, 32'd0);
    wb_xfer(1'b0, BASE + 32'h8, 32'd0, rd);
    check("rst_clkdiv", rd, 32'd1);
    wb_xfer(1'b0, BASE + 32'hC, 32'd0, rd);
    check("other_off_rd", rd, 32'd0);

    // directed: div=0 write of 0x5A to 0x08, then read of 0x01
    set_div(8'd0);
    do_frame(1'b1, 8'h08, 8'h5A, 1'b1, 1'b0);
    do_frame(1'b0, 8'h01, 8'h00, 1'b0, 1'b0);
    // div=3 with overlapping CTRL and CLKDIV writes mid-frame
    set_div(8'd3);
    do_frame(1'b1, 8'h11, 8'hC3, 1'b1, 1'b1);
    wb_xfer(1'b0, BASE + 32'h8, 32'd0, rd);
    check("div_after_busy_wr", rd, 32'd2);
    // random frames
    for (int i = 0; i < 5; i++) begin
      set_div(8'($urandom_range(0, 3)));
      do_frame(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end
    // slowest divider
    set_div(8'd255);
    do_frame(1'b0, 8'h02, 8'h00, 1'b0, 1'b0);

    // reset after bit 10 of a frame
    set_div(8'd1);
    resp = 24'hFFFFFF;
    wb_xfer(1'b1, BASE, 32'h0000_0033, rd);
    k = 0;
    while (rises < 11 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("bit10_reached", rises, 11);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_csb", {31'd0, csb}, 32'd1);
    check("midrst_sck", {31'd0, sck}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_div = 8'd1;
    m_rdata = 8'd0;
    m_ien = 1'b0;
    wb_xfer(1'b0, BASE + 32'h4, 32'd0, rd);
    check("midrst_status", rd, 32'd0);
    wb_xfer(1'b0, BASE + 32'h8, 32'd0, rd);
    check("midrst_clkdiv", rd, 32'd1);
    do_frame(1'b0, 8'h01, 8'h00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
